// File: rtl/cnn_conv_acc_relu.sv
// Convolution window accumulator with bias, arithmetic output shift and clipped ReLU.
// Sums KSIZE products per window and emits one 14-bit activated result per window.
module cnn_conv_acc_relu #(
   parameter int KSIZE     = 25,
   parameter int OUT_SHIFT = 6
) (
   input  logic               ap_clk,
   input  logic               ap_rst_n,
   input  logic               clr,
   input  logic               prod_vld,
   input  logic signed [19:0] prod_data,
   output logic               prod_rdy,
   input  logic signed [13:0] bias,
   output logic               out_vld,
   output logic signed [13:0] out_data,
   output logic               out_sat,
   input  logic               out_rdy
);

   localparam int CntW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(KSIZE - 1);

   typedef enum logic [1:0] {StIdle, StAcc, StOut} state_e;

   state_e                state_q;
   logic signed [31:0]    acc_q;
   logic [CntW-1:0]       cnt_q;
   logic                  prod_rdy_q;
   logic                  out_vld_q;
   logic signed [13:0]    out_data_q;
   logic                  out_sat_q;

   logic                  beat;
   logic                  last;
   logic signed [31:0]    base;
   logic signed [31:0]    sum;
   logic signed [31:0]    t;
   logic signed [13:0]    res;
   logic                  res_sat;

   always_comb begin
      beat = prod_vld && prod_rdy_q;
      // First beat of a window starts from the pre-scaled bias instead of the accumulator.
      base = (state_q == StIdle) ? (32'(bias) <<< OUT_SHIFT) : acc_q;
      sum  = base + 32'(prod_data);
      t    = sum >>> OUT_SHIFT;
      last = (state_q == StIdle) ? (KSIZE == 1) : (cnt_q == CntLast);
      res     = '0;
      res_sat = 1'b0;
      if (t < 0) begin
         res = '0;
      end else if (t > 32'sd8191) begin
         res     = 14'sd8191;
         res_sat = 1'b1;
      end else begin
         res = t[13:0];
      end
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q    <= StIdle;
         acc_q      <= '0;
         cnt_q      <= '0;
         prod_rdy_q <= 1'b0;
         out_vld_q  <= 1'b0;
         out_data_q <= '0;
         out_sat_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StAcc: begin
               prod_rdy_q <= 1'b1;
               if (clr) begin
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  state_q <= StIdle;
               end else if (beat) begin
                  acc_q <= sum;
                  if (last) begin
                     cnt_q      <= '0;
                     state_q    <= StOut;
                     out_vld_q  <= 1'b1;
                     out_data_q <= res;
                     out_sat_q  <= res_sat;
                     prod_rdy_q <= 1'b0;
                  end else begin
                     cnt_q   <= (state_q == StIdle) ? CntW'(1) : cnt_q + CntW'(1);
                     state_q <= StAcc;
                  end
               end
            end
            StOut: begin
               // clr is deliberately ignored here so a finished result is never dropped.
               if (out_rdy) begin
                  state_q    <= StIdle;
                  out_vld_q  <= 1'b0;
                  prod_rdy_q <= 1'b1;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign prod_rdy = prod_rdy_q;
   assign out_vld  = out_vld_q;
   assign out_data = out_data_q;
   assign out_sat  = out_sat_q;

endmodule

// File: doc/cnn_conv_acc_relu.md
CNN_CONV_ACC_RELU -- requirements
Module: cnn_conv_acc_relu

Interface
REQ-001 SHALL have parameter KSIZE, default 25: products per output window (legal range 1..2048).
REQ-002 SHALL have parameter OUT_SHIFT, default 6: arithmetic right shift applied to the final sum (legal range 0..16).
REQ-003 SHALL have port ap_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port clr, input, 1 bit: synchronous discard of the partial window.
REQ-006 SHALL have port prod_vld, input, 1 bit: prod_data is valid.
REQ-007 SHALL have port prod_data, input, 20 bits, signed: product from the upstream 6ns x 14s multiplier.
REQ-008 SHALL have port prod_rdy, output, 1 bit: block accepts a product this cycle.
REQ-009 SHALL have port bias, input, 14 bits, signed: window bias, sampled on the first accepted beat of each window.
REQ-010 SHALL have port out_vld, output, 1 bit: out_data is valid.
REQ-011 SHALL have port out_data, output, 14 bits, signed: activated result.
REQ-012 SHALL have port out_sat, output, 1 bit: result was clipped at the top; valid with out_vld.
REQ-013 SHALL have port out_rdy, input, 1 bit: downstream accepts out_data.

Function
REQ-014 SHALL implement FSM states IDLE, ACC and OUT.
REQ-015 SHALL drive prod_rdy=1 in IDLE and ACC, and prod_rdy=0 in OUT.
REQ-016 SHALL define a beat as prod_vld&&prod_rdy in the same cycle; prod_data SHALL be ignored in all other cycles.
REQ-017 SHALL hold a 32-bit signed accumulator acc and a beat counter cnt counting 0..KSIZE-1.
REQ-018 SHALL, on a beat in IDLE: load acc = sext(prod_data) + (sext(bias) <<< OUT_SHIFT), set cnt=1, go to ACC (or go directly to OUT when KSIZE=1).
REQ-019 SHALL, on a beat in ACC: set acc = acc + sext(prod_data) and increment cnt.
REQ-020 SHALL treat the beat that makes cnt reach KSIZE as the last beat; on it, cnt SHALL wrap to 0 and the FSM SHALL go to OUT.
REQ-021 SHALL, on the last beat, register out_data from the final sum S (acc including that beat), so that out_vld=1 the next cycle (latency 1 cycle after the last beat).
REQ-022 SHALL compute out_data as follows: T = S >>> OUT_SHIFT (arithmetic shift, floor); T<0 gives 0; T>8191 gives 8191 with out_sat=1; otherwise T with out_sat=0.
REQ-023 SHALL hold out_vld, out_data and out_sat stable in OUT until out_vld&&out_rdy.
REQ-024 SHALL, on out_vld&&out_rdy, return to IDLE and deassert out_vld the next cycle; prod_rdy SHALL be 1 in that same next cycle.
REQ-025 SHALL, on clr=1 in IDLE or ACC, set acc=0 and cnt=0 and go to IDLE; any simultaneous beat SHALL be discarded.
REQ-026 SHALL ignore clr in OUT; a pending result is never dropped.
REQ-027 SHALL guarantee no accumulator overflow for the legal ranges (|S| < 2^31).

Reset
REQ-028 SHALL, while ap_rst_n=0, immediately force: state=IDLE, acc=0, cnt=0, out_vld=0, out_data=0, out_sat=0, prod_rdy=0.
REQ-029 SHALL drive prod_rdy=1 from the first rising edge after ap_rst_n deasserts.
REQ-030 SHALL, when reset is asserted mid-window or in OUT, lose the partial window or pending result, with no output emitted.

Verification (KSIZE=25, OUT_SHIFT=6)
REQ-031 Basic window: bias=0, 25 beats of 64 -> out_vld 1 cycle after beat 25, out_data=25, out_sat=0.
REQ-032 ReLU: bias=0, 25 beats of -100 (S=-2500) -> out_data=0, out_sat=0.
REQ-033 Saturation: bias=8191, 25 beats of 524287 -> out_data=8191, out_sat=1.
REQ-034 Backpressure: out_rdy=0 for 5 cycles with prod_vld=1 -> out_data held, prod_rdy=0, no beats counted; the next window after the handshake sums correctly.
REQ-035 Reset/clr mid-window: assert ap_rst_n=0 after 10 beats (and, separately, clr after 10 beats), then bias=2 with 25 zero beats -> out_data=2, with no earlier output.
REQ-036 Back-to-back: two windows with prod_vld and out_rdy held high -> outputs are spaced KSIZE+1 cycles apart, and the second window sum is unaffected by the first.
